// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and constants for the Game-of-Life neighbour sequencer
package life_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // A count of 4 stands for "4 or more" neighbours
  localparam logic [2:0] COUNT_SAT      = 3'd4;

  // Rule masks indexed by clamped count: Conway B3/S23
  localparam logic [4:0] CONWAY_BIRTH   = 5'b01000;
  localparam logic [4:0] CONWAY_SURVIVE = 5'b01100;

  typedef struct packed {
    logic [7:0] neighbors;
    logic       alive;
  } cell_job_t;

endpackage

// File: rtl/life_neighbor_sequencer_adder.sv
// rtl/life_neighbor_sequencer_adder.sv - FULL_ADDER_2_BIT_TO_3_BIT, 2-bit plus 2-bit into a 3-bit sum
module FULL_ADDER_2_BIT_TO_3_BIT (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic [2:0] SUM
);

  // Plain unsigned add; the carry lands in SUM[2]
  always_comb begin
    SUM = {1'b0, A} + {1'b0, B};
  end

endmodule

// File: rtl/life_neighbor_sequencer.sv
// rtl/life_neighbor_sequencer.sv - time-shared 3-level neighbour reduction and next-state rule
module life_neighbor_sequencer
  import life_pkg::*;
#(
  parameter logic [4:0] BIRTH_MASK   = CONWAY_BIRTH,
  parameter logic [4:0] SURVIVE_MASK = CONWAY_SURVIVE
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] NEIGHBORS,
  input  logic       ALIVE,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [2:0] COUNT,
  output logic       NEXT_ALIVE
);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  cell_job_t  job_q;
  logic [1:0] p_q [4];
  logic [2:0] q_q [2];
  logic [2:0] count_q;
  logic       next_alive_q;
  logic       out_valid_q;

  logic [1:0] add_a, add_b;
  logic [2:0] add_sum;
  logic       sat;
  logic [2:0] count_l3;
  logic       next_alive_l3;

  // The only adder in the block, shared by every reduction level
  FULL_ADDER_2_BIT_TO_3_BIT u_adder (
    .A   (add_a),
    .B   (add_b),
    .SUM (add_sum)
  );

  // Steer the shared adder: pairs of neighbour bits, then pair sums, then the two halves
  always_comb begin
    add_a = 2'b00;
    add_b = 2'b00;
    sat   = q_q[0][2] | q_q[1][2];
    case (state_q)
      ST_L1: begin
        add_a = {1'b0, job_q.neighbors[{idx_q, 1'b0}]};
        add_b = {1'b0, job_q.neighbors[{idx_q, 1'b1}]};
      end
      ST_L2: begin
        add_a = p_q[{idx_q[0], 1'b0}];
        add_b = p_q[{idx_q[0], 1'b1}];
      end
      ST_L3: begin
        // A half already at 4 decides the result, so the adder idles at 0
        if (!sat) begin
          add_a = q_q[0][1:0];
          add_b = q_q[1][1:0];
        end
      end
      default: begin
        add_a = 2'b00;
        add_b = 2'b00;
      end
    endcase
  end

  // Final clamp and rule lookup used on the L3 cycle
  always_comb begin
    count_l3      = sat ? COUNT_SAT : ((add_sum > COUNT_SAT) ? COUNT_SAT : add_sum);
    next_alive_l3 = job_q.alive ? SURVIVE_MASK[count_l3] : BIRTH_MASK[count_l3];
  end

  // Next state and reduction index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          state_d = ST_L1;
          idx_d   = 2'd0;
        end
      end
      ST_L1: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = ST_L2;
          idx_d   = 2'd0;
        end
      end
      ST_L2: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd1) begin
          state_d = ST_L3;
          idx_d   = 2'd0;
        end
      end
      ST_L3:   state_d = ST_DONE;
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Control and datapath registers; reset drops any job in flight
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      out_valid_q  <= 1'b0;
      count_q      <= 3'd0;
      next_alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            job_q.neighbors <= NEIGHBORS;
            job_q.alive     <= ALIVE;
          end
        end
        ST_L1: p_q[idx_q]    <= add_sum[1:0];
        ST_L2: q_q[idx_q[0]] <= add_sum;
        ST_L3: begin
          count_q      <= count_l3;
          next_alive_q <= next_alive_l3;
          out_valid_q  <= 1'b1;
        end
        ST_DONE: begin
          if (OUT_READY) out_valid_q <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign IN_READY   = RST_N && (state_q == ST_IDLE);
  assign OUT_VALID  = out_valid_q;
  assign COUNT      = count_q;
  assign NEXT_ALIVE = next_alive_q;

endmodule

// File: tb/tb_life_neighbor_sequencer.sv
// tb/tb_life_neighbor_sequencer.sv - self-checking bench for life_neighbor_sequencer
module tb_life_neighbor_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] neighbors;
  logic       alive;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       next_alive;

  int vectors;
  int miscompares;

  life_neighbor_sequencer dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .IN_VALID   (in_valid),
    .IN_READY   (in_ready),
    .NEIGHBORS  (neighbors),
    .ALIVE      (alive),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .COUNT      (count),
    .NEXT_ALIVE (next_alive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count live neighbours, clamp at 4, apply B3/S23
  function automatic logic [2:0] ref_count(input logic [7:0] n);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(n[i]);
    return (c > 4) ? 3'd4 : 3'(c);
  endfunction

  function automatic logic ref_next(input logic [7:0] n, input logic a);
    int c;
    c = int'(ref_count(n));
    return a ? (c == 2 || c == 3) : (c == 3);
  endfunction

  // Submit one job from a negedge; lat counts rising edges from the accept edge (inclusive)
  // until OUT_VALID is seen, or 99 if it never comes
  task automatic run_job(input logic [7:0] n, input logic a,
                         output logic [2:0] c, output logic na, output int lat);
    int k;
    in_valid  = 1'b1;
    neighbors = n;
    alive     = a;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    neighbors = 8'($urandom);
    alive     = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    c  = count;
    na = next_alive;
    if (!out_valid) lat = 99;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0 || next_alive !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle: got ov=%b cnt=%0d na=%b ir=%b want 0 0 0 1",
               out_valid, count, next_alive, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [7:0] pats [4];
    logic       alv  [4];
    logic [2:0] exp_c [4];
    logic       exp_n [4];
    logic [2:0] c;
    logic       na;
    int         lat;
    pats[0] = 8'b0001_0101; alv[0] = 1'b0; exp_c[0] = 3'd3; exp_n[0] = 1'b1;
    pats[1] = 8'b1000_0001; alv[1] = 1'b1; exp_c[1] = 3'd2; exp_n[1] = 1'b1;
    pats[2] = 8'b0000_0001; alv[2] = 1'b1; exp_c[2] = 3'd1; exp_n[2] = 1'b0;
    pats[3] = 8'b0000_1111; alv[3] = 1'b0; exp_c[3] = 3'd4; exp_n[3] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_job(pats[i], alv[i], c, na, lat);
      vectors++;
      if (lat !== 8) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d edges want 8", i, lat);
      end
      vectors++;
      if (c !== exp_c[i] || na !== exp_n[i]) begin
        miscompares++;
        $display("FAIL directed_result[%0d] n=%b a=%b: got cnt=%0d na=%b want cnt=%0d na=%b",
                 i, pats[i], alv[i], c, na, exp_c[i], exp_n[i]);
      end
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_release[%0d]: got ir=%b ov=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] c;
    logic       na;
    int         lat;
    out_ready = 1'b0;
    run_job(8'hFF, 1'b1, c, na, lat);
    vectors++;
    if (lat !== 8 || c !== 3'd4 || na !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_result: got lat=%0d cnt=%0d na=%b want 8 4 0", lat, c, na);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || count !== 3'd4 || next_alive !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got ov=%b cnt=%0d na=%b ir=%b want 1 4 0 0",
                 i, out_valid, count, next_alive, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_release: got ov=%b ir=%b cnt=%0d want 0 1 4", out_valid, in_ready, count);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] c;
    logic       na;
    logic       a;
    int         lat;
    int         stall;
    for (int n = 0; n < 256; n++) begin
      a     = 1'($urandom);
      stall = (($urandom % 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      out_ready = (stall == 0);
      run_job(8'(n), a, c, na, lat);
      vectors++;
      if (lat !== 8 || c !== ref_count(8'(n)) || na !== ref_next(8'(n), a)) begin
        miscompares++;
        $display("FAIL sweep n=%b a=%b: got lat=%0d cnt=%0d na=%b want 8 %0d %b",
                 8'(n), a, lat, c, na, ref_count(8'(n)), ref_next(8'(n), a));
      end
      if (stall != 0) begin
        repeat (stall) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || count !== c || next_alive !== na) begin
          miscompares++;
          $display("FAIL sweep_hold n=%b: got ov=%b cnt=%0d na=%b want 1 %0d %b",
                   8'(n), out_valid, count, next_alive, c, na);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int accepts [$];
    out_ready = 1'b1;
    in_valid  = 1'b1;
    neighbors = 8'b0011_0001;
    alive     = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_valid && in_ready) accepts.push_back(cyc);
      if (out_valid) begin
        vectors++;
        if (count !== 3'd3 || next_alive !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_result cyc=%0d: got cnt=%0d na=%b want 3 1", cyc, count, next_alive);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (accepts.size() < 4) begin
      miscompares++;
      $display("FAIL b2b_accepts: got %0d want at least 4", accepts.size());
    end
    for (int i = 1; i < accepts.size(); i++) begin
      vectors++;
      if (accepts[i] - accepts[i-1] != 9) begin
        miscompares++;
        $display("FAIL b2b_interval[%0d]: got %0d cycles want 9", i, accepts[i] - accepts[i-1]);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    logic [2:0] c;
    logic       na;
    int         lat;
    logic       seen;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    neighbors = 8'hFF;
    alive     = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd0 || next_alive !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_state: got ov=%b ir=%b cnt=%0d na=%b want 0 0 0 0",
               out_valid, in_ready, count, next_alive);
    end
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_no_output: got ov_seen=%b ir=%b want 0 1", seen, in_ready);
    end
    run_job(8'b0000_0111, 1'b1, c, na, lat);
    vectors++;
    if (lat !== 8 || c !== 3'd3 || na !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_next_job: got lat=%0d cnt=%0d na=%b want 8 3 1", lat, c, na);
    end
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    neighbors   = 8'h00;
    alive       = 1'b0;
    out_ready   = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_sweep();
    test_back_to_back();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
